// File: rtl/cell_drawer.sv
// Draws one grid cell: fetches its colour from BRAM, then plots a WIDTH x WIDTH square.
// Optional macro CELL_BORDER_EN paints the outer ring of each cell with BORDER_COLOUR.
module cell_drawer #(
    parameter int                     WIDTH         = 10,
    parameter int                     SPACING       = 2,
    parameter int                     COLOUR_W      = 3,
    parameter logic [COLOUR_W-1:0]    BORDER_COLOUR = 3'b111
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [10:0]         address,
    output logic [7:0]          mem_rdaddr,
    input  logic [COLOUR_W-1:0] mem_q,
    output logic [10:0]         pixel_x,
    output logic [10:0]         pixel_y,
    output logic [COLOUR_W-1:0] pixel_colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    localparam int               CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [10:0]      PITCH = 11'(WIDTH + SPACING);

    typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, DRAW, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [CW-1:0]       dx_q, dx_d, dy_q, dy_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [7:0]          mem_rdaddr_q, mem_rdaddr_d;
    logic [10:0]         pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
    logic [COLOUR_W-1:0] pixel_colour_q, pixel_colour_d;
    logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [10:0]         origin_x, origin_y;
    logic [COLOUR_W-1:0] colour_src;
    logic                is_border;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^address[10:8];
    assign origin_x = 11'(pos_x_q) * PITCH;
    assign origin_y = 11'(pos_y_q) * PITCH;

    always_comb begin
        state_d        = state_q;
        pos_x_d        = pos_x_q;
        pos_y_d        = pos_y_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        colour_d       = colour_q;
        mem_rdaddr_d   = mem_rdaddr_q;
        pixel_x_d      = pixel_x_q;
        pixel_y_d      = pixel_y_q;
        pixel_colour_d = pixel_colour_q;
        plot_d         = 1'b0;
        done_d         = 1'b0;
        colour_src     = colour_q;
        is_border      = 1'b0;

        case (state_q)
            IDLE: if (start) begin
                state_d      = FETCH0;
                pos_x_d      = address[3:0];
                pos_y_d      = address[7:4];
                mem_rdaddr_d = address[7:0];
            end
            FETCH0: state_d = FETCH1;
            FETCH1: begin
                // BRAM data is valid at the end of FETCH1; the first pixel
                // uses it directly since colour_q is only loaded on this edge.
                state_d    = DRAW;
                colour_d   = mem_q;
                colour_src = mem_q;
                dx_d       = '0;
                dy_d       = '0;
                plot_d     = 1'b1;
            end
            DRAW: begin
                if (dx_q == LAST) begin
                    dx_d = '0;
                    if (dy_q == LAST) begin
                        dy_d    = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        dy_d   = dy_q + 1'b1;
                        plot_d = 1'b1;
                    end
                end else begin
                    dx_d   = dx_q + 1'b1;
                    plot_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (plot_d) begin
`ifdef CELL_BORDER_EN
            is_border = (dx_d == '0) || (dx_d == LAST) || (dy_d == '0) || (dy_d == LAST);
`else
            is_border = 1'b0;
`endif
            pixel_x_d      = origin_x + 11'(dx_d);
            pixel_y_d      = origin_y + 11'(dy_d);
            pixel_colour_d = is_border ? BORDER_COLOUR : colour_src;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            pos_x_q        <= '0;
            pos_y_q        <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            colour_q       <= '0;
            mem_rdaddr_q   <= '0;
            pixel_x_q      <= '0;
            pixel_y_q      <= '0;
            pixel_colour_q <= '0;
            plot_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pos_x_q        <= pos_x_d;
            pos_y_q        <= pos_y_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            colour_q       <= colour_d;
            mem_rdaddr_q   <= mem_rdaddr_d;
            pixel_x_q      <= pixel_x_d;
            pixel_y_q      <= pixel_y_d;
            pixel_colour_q <= pixel_colour_d;
            plot_q         <= plot_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign mem_rdaddr   = mem_rdaddr_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign pixel_colour = pixel_colour_q;
    assign plot         = plot_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_cell_drawer.sv
// Scoreboard bench for cell_drawer: expected pixels/done pulses are queued at
// acceptance and popped by an independent monitor on the falling edge.
module tb_cell_drawer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [10:0] address = '0;
    logic [7:0]  mem_rdaddr;
    logic [2:0]  mem_q = '0;
    logic [10:0] pixel_x, pixel_y;
    logic [2:0]  pixel_colour;
    logic        plot, busy, done;

    cell_drawer dut (
        .clock(clock), .reset(reset), .start(start), .address(address),
        .mem_rdaddr(mem_rdaddr), .mem_q(mem_q),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_colour(pixel_colour),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    logic [2:0] mem [256];
    always @(posedge clock) mem_q <= mem[mem_rdaddr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int c; int x; int y; int col; } pix_t;
    pix_t pix_q[$];
    int   done_q[$];
    int   nvec = 0;
    int   nerr = 0;
    pix_t e;
    int   ed;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_col(input int dx, input int dy, input int c);
`ifdef CELL_BORDER_EN
        if (dx == 0 || dx == 9 || dy == 0 || dy == 9) return 7;
`endif
        return c;
    endfunction

    // Monitor: pops one expectation per plot or done strobe
    always @(negedge clock) begin
        if (reset) begin
            if (plot) begin
                nvec++;
                if (pix_q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_plot: got (%0d,%0d) at cyc %0d, expected none", pixel_x, pixel_y, cyc);
                end else begin
                    e = pix_q.pop_front();
                    if (cyc != e.c || int'(pixel_x) != e.x || int'(pixel_y) != e.y || int'(pixel_colour) != e.col) begin
                        nerr++;
                        $display("FAIL pixel: got cyc %0d (%0d,%0d) col %0d expected cyc %0d (%0d,%0d) col %0d",
                                 cyc, pixel_x, pixel_y, pixel_colour, e.c, e.x, e.y, e.col);
                    end
                end
            end
            if (done) begin
                nvec++;
                if (done_q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_done: got done at cyc %0d expected none", cyc);
                end else begin
                    ed = done_q.pop_front();
                    if (cyc != ed) begin
                        nerr++;
                        $display("FAIL done_time: got cyc %0d expected cyc %0d", cyc, ed);
                    end
                end
            end
            if (plot && done) begin
                nvec++;
                nerr++;
                $display("FAIL plot_done_overlap: got both high at cyc %0d expected exclusive", cyc);
            end
        end
    end

    // k = cyc value in the cycle after the accepting edge
    task automatic expect_cell(input int k, input int ox, input int oy, input int c, input int n);
        for (int i = 0; i < n; i++)
            pix_q.push_back('{k + 2 + i, ox + i % 10, oy + i / 10, exp_col(i % 10, i / 10, c)});
        if (n == 100) done_q.push_back(k + 102);
    endtask

    task automatic accept(input logic [10:0] a, output int k);
        @(negedge clock);
        start   = 1'b1;
        address = a;
        @(negedge clock);
        k = cyc;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic chk_drained(input string name);
        chk({name, "_pix_left"}, pix_q.size(), 0);
        chk({name, "_done_left"}, done_q.size(), 0);
    endtask

    int k;
    int c0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 3'd0;
`ifdef CELL_BORDER_EN
        c0 = 2;
`else
        c0 = 5;
`endif
        mem[0] = 3'(c0); mem[17] = 3'd3; mem[255] = 3'd6;
        mem[1] = 3'd1;   mem[2]  = 3'd4; mem[3]   = 3'd2; mem[4] = 3'd7;

        repeat (3) @(negedge clock);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_px", pixel_x, 0);
        chk("rst_py", pixel_y, 0);
        chk("rst_col", pixel_colour, 0);
        chk("rst_rdaddr", mem_rdaddr, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // address 0: origin (0,0)
        accept(11'd0, k);
        start = 1'b0;
        chk("a0_rdaddr", mem_rdaddr, 0);
        chk("a0_busy_rise", busy, 1);
        expect_cell(k, 0, 0, c0, 100);
        wait_cyc(k + 103);
        chk("a0_busy_fall", busy, 0);
        chk("a0_done_low", done, 0);
        chk_drained("a0");

        // address 17: origin (12,12)
        accept(11'd17, k);
        start = 1'b0;
        chk("a17_rdaddr", mem_rdaddr, 17);
        expect_cell(k, 12, 12, 3, 100);
        wait_cyc(k + 103);
        chk_drained("a17");

        // high address bits ignored: 0x7FF -> cell 255 at (180,180)
        accept(11'h7FF, k);
        start = 1'b0;
        chk("a7ff_rdaddr", mem_rdaddr, 255);
        expect_cell(k, 180, 180, 6, 100);
        wait_cyc(k + 103);
        chk_drained("a7ff");

        // start during DRAW is ignored
        accept(11'd0, k);
        start = 1'b0;
        expect_cell(k, 0, 0, c0, 100);
        wait_cyc(k + 49);
        start = 1'b1;
        address = 11'd1;
        @(negedge clock);
        start = 1'b0;
        chk("ign_rdaddr_mid", mem_rdaddr, 0);
        wait_cyc(k + 108);
        chk("ign_busy", busy, 0);
        chk("ign_rdaddr", mem_rdaddr, 0);
        chk_drained("ign");

        // reset mid-DRAW aborts without done
        accept(11'd0, k);
        start = 1'b0;
        expect_cell(k, 0, 0, c0, 37);
        wait_cyc(k + 38);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_px", pixel_x, 0);
        chk("abort_py", pixel_y, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk_drained("abort");

        // address 2 after reset: origin (24,0)
        accept(11'd2, k);
        start = 1'b0;
        chk("a2_rdaddr", mem_rdaddr, 2);
        expect_cell(k, 24, 0, 4, 100);
        wait_cyc(k + 103);
        chk_drained("a2");

        // start held high: back-to-back cells 104 cycles apart
        accept(11'd3, k);
        expect_cell(k, 36, 0, 2, 100);
        wait_cyc(k + 103);
        address = 11'd4;
        expect_cell(k + 104, 48, 0, 7, 100);
        wait_cyc(k + 104);
        start = 1'b0;
        chk("held_rdaddr", mem_rdaddr, 4);
        chk("held_busy", busy, 1);
        wait_cyc(k + 207);
        chk("held_busy_fall", busy, 0);
        chk_drained("held");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/cell_drawer.md
# cell_drawer

Consumer end of the grid sweep handshake: accepts one grid cell address from the address counter, reads that cell's colour from the board BRAM, and rasterises the cell as a WIDTH×WIDTH square of pixel writes to the VGA adapter. When the square is complete it pulses `done` back to the counter, which then advances to the next address. It sits between the address counter, the BRAM read port and the VGA adapter plot interface.

## Interface
- `WIDTH`, 10, cell edge length in pixels
- `SPACING`, 2, gap in pixels between adjacent cells
- `COLOUR_W`, 3, colour width in bits
- `BORDER_COLOUR`, 3'b111, border colour; used only with `CELL_BORDER_EN`

- `clock` in 1: single clock; all state on its rising edge
- `reset` in 1: asynchronous, active-low (0 = reset)
- `start` in 1: request to draw the cell at `address`; driven by the counter's enable
- `address` in 11: grid address; only bits [7:0] used, bits [10:8] ignored
- `mem_rdaddr` out 8: BRAM read address
- `mem_q` in COLOUR_W: BRAM read data, fixed 2-cycle latency from `mem_rdaddr`
- `pixel_x` out 11: plot x coordinate
- `pixel_y` out 11: plot y coordinate
- `pixel_colour` out COLOUR_W: plot colour
- `plot` out 1: pixel write strobe, one pixel per cycle while high
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when the cell is finished; feeds the counter's `done`

## Operation
- Address decode: posX = address[3:0], posY = address[7:4]
- Cell origin: originX = posX*(WIDTH+SPACING), originY = posY*(WIDTH+SPACING). Computed at 11 bits with no truncation. Maximum pixel is 15*12+9 = 189.
- FSM states:
  - IDLE: `start` is sampled only here. `start`=1 latches posX/posY, drives `mem_rdaddr`=address[7:0], and moves to FETCH0.
  - FETCH0 -> FETCH1: waits out the BRAM latency. At the end of FETCH1, `mem_q` is latched into the colour register and the state moves to DRAW.
  - DRAW: inner counters dx, dy, each 0..WIDTH-1, run row-major with dx as the inner loop. Each cycle the block outputs `plot`=1, `pixel_x`=originX+dx, `pixel_y`=originY+dy. After dx=dy=WIDTH-1 the state moves to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` held high continuously is allowed. Each return to IDLE accepts the current `address` on the next cycle.
- `start` outside IDLE is ignored. It does not queue and does not restart the cell.
- `mem_rdaddr` holds its value from acceptance until the next acceptance.
- Reset (async, any state) sets:
  - state = IDLE
  - `plot`, `done`, `busy` = 0
  - `pixel_x`, `pixel_y`, `pixel_colour`, `mem_rdaddr` = 0
  - dx, dy = 0
  
  Plotting stops mid-cell immediately and no `done` is produced for the aborted cell.

## Timing
- All outputs are registered.
- Take edge k as the edge at which IDLE sees `start`=1:
  - FETCH0 is cycle k+1 and FETCH1 is cycle k+2.
  - DRAW covers cycles k+3..k+102, giving exactly WIDTH² = 100 `plot` cycles.
  - `done` is high in cycle k+103; the block is back in IDLE in cycle k+104.
- Start-to-done latency = WIDTH²+3 cycles.
- The minimum accept-to-accept period with `start` held high is WIDTH²+4 = 104 cycles.
- `busy` rises in cycle k+1 and falls in cycle k+104. `busy` and `done` overlap only in cycle k+103.
- `plot` is never high in the same cycle as `done`.

## Configuration
- `CELL_BORDER_EN`
  - Defined: any pixel with dx or dy equal to 0 or WIDTH-1 gets `BORDER_COLOUR`; interior pixels get the fetched colour. For WIDTH=10 that is 36 border pixels and 64 interior pixels.
  - Undefined: all 100 pixels get the fetched colour, `BORDER_COLOUR` is unused, and timing is identical.

## Test plan
- Address 0, BRAM[0]=5, start for one cycle:
  - `mem_rdaddr`=0
  - first plot at (0,0) in cycle k+3, last plot at (9,9) in cycle k+102, 100 plots total, all colour 5
  - `done` pulse in cycle k+103
- Address 17 (posX=1, posY=1), BRAM[17]=3 -> plots cover x and y from 12 to 21 inclusive, colour 3; pixels 10 and 11 in either axis are never plotted.
- Address 11'h7FF -> decodes as 255, `mem_rdaddr`=255, plots span (180,180)..(189,189).
- `start` pulsed again in cycle k+50 with address 1 -> ignored; the cell at 0 finishes; no second fetch occurs until IDLE.
- Reset driven low at cycle k+40 during DRAW -> `plot`, `busy`, `done` and both coordinates are 0 immediately with no `done` pulse. Releasing reset and starting address 2 gives origin (24,0) and normal timing.
- With `CELL_BORDER_EN`, address 0, BRAM[0]=2, `BORDER_COLOUR`=7:
  - (0,0), (9,0), (0,5), (9,9) are colour 7
  - (1,1) and (8,8) are colour 2
  - 36 pixels are colour 7 and 64 are colour 2
